la_capture: RTL and testbench

- Trigger-based capture buffer that sits directly downstream of the logic-analyzer source mux.
- Samples the selected 128-bit LA word every cycle once armed, detects a masked-compare trigger, and keeps a window of pre- and post-trigger samples in a circular buffer.
- The captured window is then drained oldest-first over a valid/ready read port toward the host-visible register interface.

---
 rtl/la_capture.sv | 128 ++++++++++++
 tb/tb_la_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture.sv
// rtl/la_capture.sv - trigger-based LA capture buffer with pre/post-trigger window and valid/ready drain
module la_capture #(
  parameter  int DATA_W = 128,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] la_dat_in,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [PTR_W:0]    post_cnt,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_dat,
  output logic              armed,
  output logic              triggered,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  localparam logic [PTR_W:0] FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] MAX_POST = (PTR_W+1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fill, remaining;
  logic [PTR_W:0]    post_lat, post_left;

  logic              capturing;
  logic              trig_hit;
  logic              rd_fire;
  logic [PTR_W-1:0]  wr_ptr_inc;
  logic [PTR_W:0]    fill_inc;

  // Trigger compare, write-side increments and read handshake.
  always_comb begin
    capturing  = (state_q == S_ARMED) || (state_q == S_POST);
    trig_hit   = ((la_dat_in ^ trig_value) & trig_mask) == '0;
    wr_ptr_inc = wr_ptr + 1'b1;
    fill_inc   = (fill == FULL) ? fill : fill + 1'b1;
    rd_fire    = rd_valid && rd_ready;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (trig_hit) state_d = (post_lat == '0) ? S_DONE : S_POST;
      S_POST:  if (post_left == (PTR_W+1)'(1)) state_d = S_DONE;
      S_DONE:  if (rd_fire && remaining == (PTR_W+1)'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Status outputs and read port; rd_dat only ever comes from stored samples.
  always_comb begin
    armed     = (state_q == S_ARMED);
    triggered = (state_q == S_POST) || (state_q == S_DONE);
    done      = (state_q == S_DONE);
    rd_valid  = (state_q == S_DONE) && (remaining != '0);
    rd_dat    = rd_valid ? mem[rd_ptr] : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Pointers and counters; the read window is set up from post-write values on DONE entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      remaining <= '0;
      post_lat  <= '0;
      post_left <= '0;
    end else if (abort) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      remaining <= '0;
      post_lat  <= '0;
      post_left <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            wr_ptr   <= '0;
            fill     <= '0;
            post_lat <= (post_cnt > MAX_POST) ? MAX_POST : post_cnt;
          end
        end
        S_ARMED, S_POST: begin
          wr_ptr <= wr_ptr_inc;
          fill   <= fill_inc;
          if (state_q == S_ARMED && trig_hit) post_left <= post_lat;
          if (state_q == S_POST) post_left <= post_left - 1'b1;
          if (state_d == S_DONE) begin
            rd_ptr    <= (fill_inc == FULL) ? wr_ptr_inc : '0;
            remaining <= fill_inc;
          end
        end
        S_DONE: begin
          if (rd_fire) begin
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample storage; contents are not reset, validity is tracked by fill.
  always_ff @(posedge clk) begin
    if (capturing && !abort) mem[wr_ptr] <= la_dat_in;
  end

endmodule

// File: tb/tb_la_capture.sv
// tb/tb_la_capture.sv - scoreboard bench for la_capture
module tb_la_capture;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic [DATA_W-1:0] la_dat_in;
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] trig_mask;
  logic [DATA_W-1:0] trig_value;
  logic [PTR_W:0]    post_cnt;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_dat;
  logic              armed;
  logic              triggered;
  logic              done;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int data_mode = 0;
  logic [DATA_W-1:0] exp_q[$];

  la_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .la_dat_in  (la_dat_in),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_cnt   (post_cnt),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_dat     (rd_dat),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] data_of(input int i, input int mode);
    if (mode == 0) return DATA_W'(i);
    return {32'hDEAD_0000 | 32'(i), ~32'(i), 32'(i * 7), 32'(i)};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_window(input int first, input int last);
    for (int k = first; k <= last; k++) exp_q.push_back(data_of(k, data_mode));
  endtask

  task automatic arm_pulse();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Feeds sample c on the c-th ARMED/POST cycle until DONE; checks sample count and trigger timing.
  task automatic run_capture(input int exp_n, input int trig_idx);
    int n;
    n = 0;
    arm_pulse();
    for (int c = 0; c < 200; c++) begin
      if (done) break;
      if (trig_idx >= 0) chk("trig_timing", DATA_W'(triggered), DATA_W'(c > trig_idx));
      la_dat_in = data_of(c, data_mode);
      n++;
      @(negedge clk);
    end
    chk("capture_done", DATA_W'(done), 1);
    chk("sample_count", DATA_W'(n), DATA_W'(exp_n));
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      if (!done) break;
      @(negedge clk);
    end
    chk("drain_idle", DATA_W'({armed, triggered, done, rd_valid}), 0);
    chk("queue_empty", DATA_W'(exp_q.size()), 0);
  endtask

  // Ready driver, updated just after each rising edge.
  initial begin
    int idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      idx++;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (idx % 3 == 0);
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_dat = '0;
  always @(negedge clk) begin
    if (prev_stall && rd_valid) chk("rd_hold", rd_dat, prev_dat);
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%0h required=none", rd_dat);
      end else begin
        chk("read_data", rd_dat, exp_q.pop_front());
      end
    end
    prev_stall = rd_valid && !rd_ready;
    prev_dat   = rd_dat;
  end

  initial begin
    nrst = 1'b0; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0; la_dat_in = '0;
    trig_mask = '0; trig_value = '0; post_cnt = '0;
    #12;
    chk("reset_outputs", DATA_W'({armed, triggered, done, rd_valid}), 0);
    chk("reset_rd_dat", rd_dat, 0);
    @(negedge clk);
    nrst = 1'b1;

    // Wrapped capture: trigger at 20, 3 post samples, oldest 8..23.
    data_mode = 0; trig_mask = '1; trig_value = 128'd20; post_cnt = 5'd3;
    push_window(8, 23);
    run_capture(24, 20);
    drain();

    // Early trigger, no wrap: reads 0..3 from slot 0.
    trig_value = 128'd1; post_cnt = 5'd2;
    push_window(0, 3);
    run_capture(4, 1);
    drain();

    // Mask zero triggers immediately, post 0: single sample.
    trig_mask = '0; trig_value = 128'd77; post_cnt = 5'd0;
    push_window(0, 0);
    run_capture(1, 0);
    drain();

    // post_cnt 31 clamps to 15: trigger sample 5 is oldest.
    trig_mask = '1; trig_value = 128'd5; post_cnt = 5'd31;
    push_window(5, 20);
    run_capture(21, 5);
    drain();

    // Partial mask on low byte, stalling reader with 1,0,0 ready pattern.
    data_mode = 1; ready_mode = 1;
    trig_mask = 128'hFF; trig_value = {96'h1234_5678_9ABC, 32'h0000_0009}; post_cnt = 5'd4;
    push_window(0, 13);
    run_capture(14, 9);
    drain();
    ready_mode = 0; data_mode = 0;

    // arm together with abort in IDLE stays IDLE.
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_idle", DATA_W'(armed), 0);

    // Abort during POST.
    trig_mask = '1; trig_value = 128'd3; post_cnt = 5'd10;
    arm_pulse();
    for (int c = 0; c < 6; c++) begin
      la_dat_in = data_of(c, 0);
      @(negedge clk);
    end
    chk("post_triggered", DATA_W'({armed, triggered, done}), DATA_W'(3'b010));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_post_idle", DATA_W'({armed, triggered, done, rd_valid}), 0);

    // Abort during DONE while readout is stalled.
    ready_mode = 2;
    trig_mask = '0; post_cnt = 5'd2;
    run_capture(3, -1);
    repeat (3) @(negedge clk);
    chk("done_valid", DATA_W'({done, rd_valid}), DATA_W'(2'b11));
    chk("done_first", rd_dat, data_of(0, 0));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_idle", DATA_W'({armed, triggered, done, rd_valid}), 0);
    ready_mode = 0;

    // Async reset while ARMED.
    trig_mask = '1; trig_value = '1; post_cnt = 5'd1;
    arm_pulse();
    for (int c = 0; c < 4; c++) begin
      la_dat_in = data_of(c, 0);
      @(negedge clk);
    end
    chk("armed_before_rst", DATA_W'(armed), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst", DATA_W'({armed, triggered, done, rd_valid}), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Fresh capture after recovery.
    trig_value = 128'd1; post_cnt = 5'd2;
    push_window(0, 3);
    run_capture(4, 1);
    drain();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
